// File: rtl/regfile_mp.sv
// Multi-port integer register file: N combinational read ports, one write port,
// optional write-to-read bypass, sticky IRQ-pending register and load scoreboard.

module regfile_mp_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int IRQ_REG    = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic [ADR_WIDTH-1:0]  ra,
    input  logic [DATA_WIDTH-1:0] stored,
    input  logic                  stored_busy,
    input  logic                  irq_pend,
    input  logic                  we,
    input  logic [ADR_WIDTH-1:0]  wa,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  busy
);
    localparam logic [ADR_WIDTH-1:0] IRQ_ADR = ADR_WIDTH'(IRQ_REG);

    logic fwd;
    assign fwd = BYPASS && we && (wa == ra);

    always_comb begin
        rd   = stored;
        busy = stored_busy;
        if (ra == '0) begin
            rd   = '0;
            busy = 1'b0;
        end else if (ra == IRQ_ADR) begin
            // Flag reads are always the registered value, never the write data.
            rd   = {DATA_WIDTH{irq_pend}};
            busy = 1'b0;
        end else if (fwd) begin
            rd   = wd;
            busy = 1'b0;
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int NUM_RD     = 2,
    parameter int IRQ_REG    = 4,
    parameter int DBG_REG    = 10,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_RD*ADR_WIDTH-1:0]  ra_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_o,
    output logic [NUM_RD-1:0]            busy_o,
    input  logic                         we_i,
    input  logic [ADR_WIDTH-1:0]         wa_i,
    input  logic [DATA_WIDTH-1:0]        wd_i,
    input  logic                         busy_set_i,
    input  logic [ADR_WIDTH-1:0]         busy_addr_i,
    input  logic                         irq_i,
    input  logic                         irq_ack_i,
    output logic [DATA_WIDTH-1:0]        dbg_o
);
    localparam int NREG = 2 ** ADR_WIDTH;
    localparam logic [ADR_WIDTH-1:0] IRQ_ADR = ADR_WIDTH'(IRQ_REG);

    typedef struct packed {
        logic                  en;
        logic [ADR_WIDTH-1:0]  adr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t                              wr;
    logic [NREG-1:0][DATA_WIDTH-1:0]      regs;
    logic [NREG-1:0]                      busy;
    logic [NREG-1:0]                      busy_set_vec;
    logic [NREG-1:0]                      busy_clr_vec;
    logic                                 irq_pend;
    logic                                 wr_store;
    logic                                 wr_irq;
    logic [NUM_RD-1:0][ADR_WIDTH-1:0]     ra;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd;

    assign wr       = '{en: we_i, adr: wa_i, data: wd_i};
    assign wr_store = wr.en && (wr.adr != '0) && (wr.adr != IRQ_ADR);
    assign wr_irq   = wr.en && (wr.adr == IRQ_ADR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) regs <= '0;
        else if (wr_store) regs[wr.adr] <= wr.data;
    end

    // One-hot set/clear masks; set is applied after clear so a new load wins.
    always_comb begin
        busy_set_vec = '0;
        busy_clr_vec = '0;
        if (busy_set_i && (busy_addr_i != '0) && (busy_addr_i != IRQ_ADR))
            busy_set_vec[busy_addr_i] = 1'b1;
        if (wr.en)
            busy_clr_vec[wr.adr] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy <= '0;
        else         busy <= (busy & ~busy_clr_vec) | busy_set_vec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    irq_pend <= 1'b0;
        else if (irq_i)                 irq_pend <= 1'b1;
        else if (irq_ack_i || wr_irq)   irq_pend <= 1'b0;
    end

    assign ra   = ra_i;
    assign rd_o = rd;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADR_WIDTH (ADR_WIDTH),
            .IRQ_REG   (IRQ_REG),
            .BYPASS    (BYPASS)
        ) u_rdport (
            .ra         (ra[k]),
            .stored     (regs[ra[k]]),
            .stored_busy(busy[ra[k]]),
            .irq_pend   (irq_pend),
            .we         (wr.en),
            .wa         (wr.adr),
            .wd         (wr.data),
            .rd         (rd[k]),
            .busy       (busy_o[k])
        );
    end

    assign dbg_o = regs[DBG_REG];
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the core's integer register file: a configurable number of combinational read ports, one write port, and optional write-to-read bypass. It adds a sticky interrupt-pending flag mapped onto a reserved register index, and a per-register busy scoreboard so the pipeline can stall on outstanding loads. It sits in the decode stage and feeds the ALU and branch operand muxes; dbg_o feeds the top-level debug output.

Parameters:
DATA_WIDTH, 32, register width in bits
ADR_WIDTH, 5, register index width; 2**ADR_WIDTH registers
NUM_RD, 2, number of read ports (1..4)
IRQ_REG, 4, index that reads as the replicated interrupt-pending flag
DBG_REG, 10, index continuously exported on dbg_o
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous, active-low reset
ra_i  in  NUM_RD*ADR_WIDTH  read addresses; port k uses slice k
rd_o  out  NUM_RD*DATA_WIDTH  read data; port k uses slice k
busy_o  out  NUM_RD  port k's addressed register has a pending write
we_i  in  1  write enable
wa_i  in  ADR_WIDTH  write address
wd_i  in  DATA_WIDTH  write data
busy_set_i  in  1  mark busy_addr_i as pending (load issued)
busy_addr_i  in  ADR_WIDTH  register to mark busy
irq_i  in  1  interrupt request level
irq_ack_i  in  1  clear interrupt-pending flag
dbg_o  out  DATA_WIDTH  stored value of register DBG_REG

Behaviour:
- Reset (rst_ni=0, asynchronous): all registers = 0, irq_pend = 0, all busy bits = 0. Hence dbg_o = 0, busy_o = 0, and rd_o = 0 for every address while reset is held. Release takes effect on the next rising edge.
- Register 0: always reads 0, never busy. Writes and busy_set to it are ignored.
- Read ports: combinational, zero latency. Evaluate each port k in this priority order:
  1. ra==0: return 0.
  2. ra==IRQ_REG: return {DATA_WIDTH{irq_pend}} (registered flag, not bypassed).
  3. BYPASS=1, we_i=1, wa_i==ra: return wd_i.
  4. Otherwise: return the stored value.
- Write: on a rising edge with we_i=1 and wa_i not 0 and not IRQ_REG, regs[wa_i] <= wd_i.
- A write to IRQ_REG does not store data; it clears irq_pend, with the same effect as irq_ack_i.
- irq_pend update per edge:
  - irq_i=1: set to 1. Set wins over any same-cycle clear.
  - Else, irq_ack_i=1 or a write to IRQ_REG: clear to 0.
  - Else: hold.
  - Rising-edge-to-read latency is 1 cycle: irq_i sampled at edge N is visible on reads after edge N.
- Scoreboard, busy[i] per register, updated at the edge:
  - Cleared when we_i=1 and wa_i==i.
  - Set when busy_set_i=1 and busy_addr_i==i.
  - Set and clear on the same index in the same cycle: set wins (new load overrides retiring write).
  - Indices 0 and IRQ_REG are never set.
- busy_o[k] = busy[ra_k], forced 0 if ra_k is 0 or IRQ_REG. When BYPASS=1, also forced 0 if we_i=1 and wa_i==ra_k in the same cycle, because the data is being forwarded. When BYPASS=0, no combinational masking is applied.
- dbg_o = stored regs[DBG_REG]. Never bypassed; updates the cycle after the write.
- Read ports with equal addresses return identical data. No port-ordering effects.

Test Plan:
- Reset/zero: hold rst_ni=0 mid-run after writing 0xDEADBEEF to x5 -> rd_o=0, dbg_o=0, busy_o=0. Write 0x1234 to x0 after release -> reading x0 returns 0.
- Write/read/bypass: BYPASS=1, we_i=1, wa=7, wd=0xA5A5A5A5 with ra0=7 in the same cycle -> rd_o[0]=0xA5A5A5A5 in that cycle. Rerun with BYPASS=0 -> old value that cycle, new value the next cycle.
- Interrupt: pulse irq_i one cycle -> reads of x4 give 0xFFFFFFFF from the next cycle. Assert irq_i and irq_ack_i together -> stays 0xFFFFFFFF. irq_ack_i alone -> 0. Write 0x55 to x4 while pending -> x4 reads 0.
- Scoreboard: busy_set_i on x9 -> busy_o=1 for ra=9. Write x9 -> busy_o=1→0 (0 in the write cycle when BYPASS=1). busy_set_i and we_i on x9 same cycle -> x9 stays busy.
- Debug/multiport: NUM_RD=4, write 0x42 to x10 -> dbg_o=0x42 the next cycle. All four ports addressing x10 -> all return 0x42.
